if_fetch_sq: RTL

Dual-issue instruction-fetch stage that generates the fetch PC and issues 8-byte packet requests to the instruction SRAM-like port. It buffers returned packets in a small queue and delivers up to two instructions per cycle (line1/line2) to the decode stage through the valid/allowin handshake. It is the producer end of the decode stage's interface: it consumes the decode stage's branch redirect `{branch_flush, branch_pc}` and the global exception flush, and retargets fetch accordingly.

---
 rtl/if_fetch_sq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/if_fetch_sq.sv
// if_fetch_sq: dual-issue instruction fetch with a small packet queue feeding decode.
// At most one packet request is outstanding; redirects drop in-flight responses via discard.
module if_fetch_sq #(
   parameter logic [31:0] RESET_PC = 32'h1C00_0000,
   parameter int unsigned QDEPTH   = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          branch_flush_i,
   input  logic [31:0]   branch_pc_i,
   input  logic          excep_flush_i,
   input  logic [31:0]   excep_pc_i,
   output logic          inst_req_o,
   output logic [31:0]   inst_addr_o,
   input  logic          inst_addr_ok_i,
   input  logic          inst_data_ok_i,
   input  logic [63:0]   inst_rdata_i,
   input  logic          next_allowin_i,
   output logic          line1_to_next_valid_o,
   output logic          line2_to_next_valid_o,
   output logic [127:0]  to_next_obus
);
   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t         state;
   logic [31:0]    fetch_pc;
   logic [31:0]    req_pc;
   logic           discard;
   logic [31:0]    q_pc   [QDEPTH];
   logic [63:0]    q_data [QDEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic [CW-1:0]  count;

   logic           flush;
   logic [31:0]    flush_pc;
   logic           empty;
   logic [31:0]    head_pc;
   logic [63:0]    head_data;
   logic [31:0]    line1_inst;
   logic           line1_valid;
   logic           push;
   logic           pop;
   logic           inflight;
   logic [CW:0]    occ;
   logic           credit;

   always_comb begin
      flush       = excep_flush_i | branch_flush_i;
      flush_pc    = excep_flush_i ? excep_pc_i : branch_pc_i;
      empty       = (count == '0);
      head_pc     = q_pc[rd_ptr];
      head_data   = q_data[rd_ptr];
      line1_inst  = head_pc[2] ? head_data[63:32] : head_data[31:0];
      line1_valid = ~empty & ~flush;
      pop         = line1_valid & next_allowin_i;
      push        = (state == WAIT) & inst_data_ok_i & ~discard & ~flush;
      inflight    = (state == WAIT) & ~discard;
      // Occupancy after this cycle's pop, plus the slot the live request will fill.
      occ         = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight);
      credit      = occ < (CW+1)'(QDEPTH);
   end

   always_comb begin
      inst_req_o            = (state == REQ);
      inst_addr_o           = {fetch_pc[31:3], 3'b000};
      line1_to_next_valid_o = line1_valid;
      line2_to_next_valid_o = line1_valid & ~head_pc[2];
      to_next_obus          = empty ? '0
                            : {head_pc + 32'd4, head_data[63:32], head_pc, line1_inst};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         discard  <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end

         unique case (state)
            IDLE: begin
               if (flush || credit) state <= REQ;
            end
            REQ: begin
               if (inst_addr_ok_i) begin
                  req_pc   <= fetch_pc;
                  fetch_pc <= {fetch_pc[31:3] + 29'd1, 3'b000};
                  state    <= WAIT;
                  if (flush) discard <= 1'b1;
               end
            end
            WAIT: begin
               if (inst_data_ok_i) begin
                  discard <= 1'b0;
                  state   <= (credit || flush) ? REQ : IDLE;
               end else if (flush) begin
                  discard <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // Placed after the FSM so a redirect wins over the addr_ok advance.
         if (flush) fetch_pc <= flush_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]   <= req_pc;
         q_data[wr_ptr] <= inst_rdata_i;
      end
   end
endmodule
